hourglass_sequencer: RTL

//  Time base and state controller for the hourglass display. Holds the fallen-sand

---
 rtl/hourglass_pkg.sv | 16 +
 rtl/sand_tick_prescaler.sv | 27 ++
 rtl/hourglass_sequencer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/hourglass_pkg.sv
// Shared definitions for the hourglass display: FSM state encoding, default sand
// geometry and the pixel coordinate width used by the sequencer, renderers and VGA top.
package hourglass_pkg;

    localparam int HG_TICK_DIV = 2_500_000;
    localparam int HG_SAND_H   = 69;
    localparam int HG_W        = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } hg_state_t;

endpackage

// File: rtl/sand_tick_prescaler.sv
// Free-running divider producing a 1-cycle sand tick every TICK_DIV enabled cycles.
// The tick is combinational from the count so a same-cycle frame_end can commit it.
module sand_tick_prescaler #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic srst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);
    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;

    assign o_tick = i_en && !i_clr && (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (srst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tick ? '0 : r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/hourglass_sequencer.sv
// Hourglass time base: owns the fallen-sand level and FSM, commits level changes only on
// frame_end, and registers the fill thresholds for the upper and lower sand renderers.
module hourglass_sequencer
    import hourglass_pkg::*;
#(
    parameter int TICK_DIV = HG_TICK_DIV,
    parameter int SAND_H   = HG_SAND_H,
    parameter int W        = HG_W
) (
    input  logic         clk,
    input  logic         BTN_S,
    input  logic         btn_start,
    input  logic         btn_flip,
    input  logic         frame_end,
    input  logic [W-1:0] ori_row,
    input  logic [W-1:0] up_top_row,
    output logic [W-1:0] lower_row,
    output logic [W-1:0] upper_row,
    output logic [1:0]   state,
    output logic         done
);
    localparam int LW = $clog2(SAND_H + 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(SAND_H);

    hg_state_t     r_state;
    logic [LW-1:0] r_level;
    logic          r_pending;
    logic          r_done;
    logic [W-1:0]  r_lower_row;
    logic [W-1:0]  r_upper_row;

    logic w_flip_act;
    logic w_tick_en;
    logic w_tick_clr;
    logic w_tick;
    logic w_commit;

    assign w_flip_act = btn_flip && (r_state == ST_RUN || r_state == ST_PAUSE);
    assign w_tick_en  = (r_state == ST_RUN);
    assign w_tick_clr = (r_state == ST_IDLE) || (r_state == ST_DONE) || w_flip_act;
    assign w_commit   = frame_end && (r_pending || w_tick);

    sand_tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .srst   (BTN_S),
        .i_en   (w_tick_en),
        .i_clr  (w_tick_clr),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (BTN_S) begin
            r_state   <= ST_IDLE;
            r_level   <= '0;
            r_pending <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_pending <= 1'b0;
                    if (btn_start && !btn_flip) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN, ST_PAUSE: begin
                    if (w_flip_act) begin
                        // Inverting swaps fallen and remaining sand; applied at once.
                        r_level   <= LVL_FULL - r_level;
                        r_pending <= 1'b0;
                    end else if (r_level == LVL_FULL) begin
                        r_state   <= ST_DONE;
                        r_done    <= 1'b1;
                        r_pending <= 1'b0;
                    end else if (r_state == ST_RUN) begin
                        if (w_commit) begin
                            r_level   <= r_level + LW'(1);
                            r_pending <= 1'b0;
                            if (r_level + LW'(1) == LVL_FULL) begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end else if (btn_start) begin
                                r_state <= ST_PAUSE;
                            end
                        end else begin
                            if (w_tick) begin
                                r_pending <= 1'b1;
                            end
                            if (btn_start) begin
                                r_state <= ST_PAUSE;
                            end
                        end
                    end else if (btn_start) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_pending <= 1'b0;
                    if (btn_flip) begin
                        r_state <= ST_RUN;
                        r_level <= '0;
                        r_done  <= 1'b0;
                    end else if (btn_start) begin
                        r_state <= ST_IDLE;
                        r_level <= '0;
                        r_done  <= 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (BTN_S) begin
            r_lower_row <= ori_row + W'(1);
            r_upper_row <= up_top_row;
        end else begin
            r_lower_row <= ori_row + W'(1) - W'(r_level);
            r_upper_row <= up_top_row + W'(r_level);
        end
    end

    assign lower_row = r_lower_row;
    assign upper_row = r_upper_row;
    assign state     = r_state;
    assign done      = r_done;

endmodule
